// File: rtl/solver_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// solver_phase_sequencer_if
// Handshake bundle between the host / per-phase control units and the
// solver phase sequencer.
//   in_start               host start / restart pulse
//   in_abort               host abort, forces the sequencer back to IDLE
//   in_setup_done          setup datapath finished
//   in_stochastic_ready    stochastic control unit ready
//   in_probabilistic_done  probabilistic control unit finished
//   in_check_done          clause checker result valid
//   in_all_satisfied       clause checker verdict (qualified by in_check_done)
//   out_current_state      2-bit global phase code
//   out_select_stochastic  move choice made in the last SELECT
//   out_iteration_count    moves issued in the current solve
//   out_busy               solve in progress
//   out_solved             solve finished with all clauses satisfied
//   out_timeout            solve abandoned (iteration limit or watchdog)
//   out_watchdog_error     timeout was caused by the phase watchdog
// Modports: master = host/control side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface solver_phase_sequencer_if #(
  parameter int ITER_WIDTH = 16
);
  logic                  in_start;
  logic                  in_abort;
  logic                  in_setup_done;
  logic                  in_stochastic_ready;
  logic                  in_probabilistic_done;
  logic                  in_check_done;
  logic                  in_all_satisfied;
  logic [1:0]            out_current_state;
  logic                  out_select_stochastic;
  logic [ITER_WIDTH-1:0] out_iteration_count;
  logic                  out_busy;
  logic                  out_solved;
  logic                  out_timeout;
  logic                  out_watchdog_error;

  modport master (
    output in_start, in_abort, in_setup_done, in_stochastic_ready,
           in_probabilistic_done, in_check_done, in_all_satisfied,
    input  out_current_state, out_select_stochastic, out_iteration_count,
           out_busy, out_solved, out_timeout, out_watchdog_error
  );

  modport slave (
    input  in_start, in_abort, in_setup_done, in_stochastic_ready,
           in_probabilistic_done, in_check_done, in_all_satisfied,
    output out_current_state, out_select_stochastic, out_iteration_count,
           out_busy, out_solved, out_timeout, out_watchdog_error
  );
endinterface

// File: rtl/solver_phase_sequencer.sv
// ---------------------------------------------------------------------------
// solver_phase_sequencer
// Top-level phase scheduler of the MCMC constraint solver. After setup the
// initial assignment is checked; every failing check is followed by a
// one-cycle SELECT in which a 16-bit Fibonacci LFSR picks either a
// stochastic or a probabilistic move. Solves end in SOLVED, or in TIMEOUT
// when the iteration budget is used up or a waiting phase stalls too long.
// Ports:
//   in_clk    clock, all state updates on the rising edge
//   in_reset  asynchronous active-high reset
//   bus       solver_phase_sequencer_if.slave (host + control unit handshakes,
//             phase code and status outputs)
// Phase codes: 0 setup/idle/select/solved/timeout, 1 stochastic,
//              2 probabilistic, 3 checking.
// ---------------------------------------------------------------------------
module solver_phase_sequencer #(
  parameter int          ITER_WIDTH           = 16,
  parameter int          MAX_ITERATIONS       = 1000,
  parameter int          STOCHASTIC_THRESHOLD = 128,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1,
  parameter int          PHASE_TIMEOUT        = 4096,
  parameter int          WD_WIDTH             = 13
) (
  input logic                     in_clk,
  input logic                     in_reset,
  solver_phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SELECT,
    ST_STOCHASTIC,
    ST_PROBABILISTIC,
    ST_CHECK,
    ST_SOLVED,
    ST_TIMEOUT
  } state_t;

  localparam logic [ITER_WIDTH-1:0] MAX_ITER  = ITER_WIDTH'(MAX_ITERATIONS);
  localparam logic [WD_WIDTH-1:0]   WD_LIMIT  = WD_WIDTH'(PHASE_TIMEOUT - 1);
  // 9 bits so that 256 (always stochastic) is representable.
  localparam logic [8:0]            THRESH9   = 9'(STOCHASTIC_THRESHOLD);

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  sel_q, sel_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [WD_WIDTH-1:0]   wd_q, wd_d;
  logic                  wd_err_q, wd_err_d;

  logic [15:0]           lfsr_step;
  logic                  pick_stoch;
  logic                  wd_expired;
  logic                  waiting;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      sel_q    <= 1'b0;
      iter_q   <= '0;
      wd_q     <= '0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      sel_q    <= sel_d;
      iter_q   <= iter_d;
      wd_q     <= wd_d;
      wd_err_q <= wd_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    sel_d    = sel_q;
    iter_d   = iter_q;
    wd_err_d = wd_err_q;

    // Taps 16,14,13,11 (bits 15,13,12,10); shift left, feedback into bit 0.
    lfsr_step  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    pick_stoch = ({1'b0, lfsr_step[7:0]} < THRESH9);
    wd_expired = (wd_q == WD_LIMIT);
    waiting    = (state_q == ST_SETUP) || (state_q == ST_STOCHASTIC) ||
                 (state_q == ST_PROBABILISTIC) || (state_q == ST_CHECK);

    if (bus.in_abort) begin
      // Abort clears every visible result but keeps the LFSR sequence going.
      state_d  = ST_IDLE;
      sel_d    = 1'b0;
      iter_d   = '0;
      wd_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SOLVED, ST_TIMEOUT: begin
          if (bus.in_start) begin
            state_d  = ST_SETUP;
            sel_d    = 1'b0;
            iter_d   = '0;
            wd_err_d = 1'b0;
          end
        end
        ST_SETUP: begin
          if (bus.in_setup_done) begin
            state_d = ST_CHECK;
          end else if (wd_expired) begin
            state_d  = ST_TIMEOUT;
            wd_err_d = 1'b1;
          end
        end
        ST_CHECK: begin
          if (bus.in_check_done) begin
            if (bus.in_all_satisfied) begin
              state_d = ST_SOLVED;
            end else if (iter_q == MAX_ITER) begin
              state_d = ST_TIMEOUT;
            end else begin
              state_d = ST_SELECT;
            end
          end else if (wd_expired) begin
            state_d  = ST_TIMEOUT;
            wd_err_d = 1'b1;
          end
        end
        ST_SELECT: begin
          lfsr_d  = lfsr_step;
          sel_d   = pick_stoch;
          iter_d  = iter_q + 1'b1;
          state_d = pick_stoch ? ST_STOCHASTIC : ST_PROBABILISTIC;
        end
        ST_STOCHASTIC: begin
          if (bus.in_stochastic_ready) begin
            state_d = ST_CHECK;
          end else if (wd_expired) begin
            state_d  = ST_TIMEOUT;
            wd_err_d = 1'b1;
          end
        end
        ST_PROBABILISTIC: begin
          if (bus.in_probabilistic_done) begin
            state_d = ST_CHECK;
          end else if (wd_expired) begin
            state_d  = ST_TIMEOUT;
            wd_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Watchdog restarts on every phase change; an expiry always changes
    // state, so the counter never runs past WD_LIMIT.
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (waiting) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.out_current_state = 2'd0;
    case (state_q)
      ST_STOCHASTIC:    bus.out_current_state = 2'd1;
      ST_PROBABILISTIC: bus.out_current_state = 2'd2;
      ST_CHECK:         bus.out_current_state = 2'd3;
      default:          bus.out_current_state = 2'd0;
    endcase
  end

  assign bus.out_select_stochastic = sel_q;
  assign bus.out_iteration_count   = iter_q;
  assign bus.out_busy              = waiting || (state_q == ST_SELECT);
  assign bus.out_solved            = (state_q == ST_SOLVED);
  assign bus.out_timeout           = (state_q == ST_TIMEOUT);
  assign bus.out_watchdog_error    = wd_err_q && (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_solver_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_solver_phase_sequencer
// Directed bench for solver_phase_sequencer with three configurations:
//   u0 default parameters, u1 threshold 256 / 3 iterations,
//   u2 threshold 0 / 16-cycle phase watchdog.
// ---------------------------------------------------------------------------
module tb_solver_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  solver_phase_sequencer_if #(.ITER_WIDTH(16)) ifc0 ();
  solver_phase_sequencer_if #(.ITER_WIDTH(16)) ifc1 ();
  solver_phase_sequencer_if #(.ITER_WIDTH(16)) ifc2 ();

  solver_phase_sequencer #(
    .STOCHASTIC_THRESHOLD(128)
  ) u0 (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (ifc0)
  );

  solver_phase_sequencer #(
    .MAX_ITERATIONS      (3),
    .STOCHASTIC_THRESHOLD(256)
  ) u1 (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (ifc1)
  );

  solver_phase_sequencer #(
    .STOCHASTIC_THRESHOLD(0),
    .PHASE_TIMEOUT       (16),
    .WD_WIDTH            (5)
  ) u2 (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (ifc2)
  );

  // Reference LFSR state and move counter for u0.
  logic [15:0] m_lfsr;
  int          m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Mask 0xB400 selects bits 15,13,12,10; the parity is the feedback bit.
  task automatic model_next(output bit stoch);
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    stoch  = (int'(m_lfsr[7:0]) < 128);
  endtask

  // From CHECK: fail the check, pass SELECT, land in the chosen move phase.
  task automatic u0_move(output bit stoch);
    chk("u0_pre_check_phase", ifc0.out_current_state, 3);
    ifc0.in_check_done = 1'b1;
    tick();
    ifc0.in_check_done = 1'b0;
    chk("u0_select_phase", ifc0.out_current_state, 0);
    chk("u0_select_busy", ifc0.out_busy, 1);
    tick();
    model_next(stoch);
    m_count++;
    chk("u0_move_phase", ifc0.out_current_state, stoch ? 1 : 2);
    chk("u0_move_sel", ifc0.out_select_stochastic, stoch);
    chk("u0_move_count", ifc0.out_iteration_count, m_count);
  endtask

  task automatic u0_finish(input bit stoch);
    if (stoch) ifc0.in_stochastic_ready = 1'b1;
    else       ifc0.in_probabilistic_done = 1'b1;
    tick();
    ifc0.in_stochastic_ready   = 1'b0;
    ifc0.in_probabilistic_done = 1'b0;
    chk("u0_back_to_check", ifc0.out_current_state, 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: observed=expired expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit s;
    bit got;

    ifc0.in_start = 0; ifc0.in_abort = 0; ifc0.in_setup_done = 0;
    ifc0.in_stochastic_ready = 0; ifc0.in_probabilistic_done = 0;
    ifc0.in_check_done = 0; ifc0.in_all_satisfied = 0;
    ifc1.in_start = 0; ifc1.in_abort = 0; ifc1.in_setup_done = 0;
    ifc1.in_stochastic_ready = 0; ifc1.in_probabilistic_done = 0;
    ifc1.in_check_done = 0; ifc1.in_all_satisfied = 0;
    ifc2.in_start = 0; ifc2.in_abort = 0; ifc2.in_setup_done = 0;
    ifc2.in_stochastic_ready = 0; ifc2.in_probabilistic_done = 0;
    ifc2.in_check_done = 0; ifc2.in_all_satisfied = 0;

    // ---- reset state
    tick(2);
    chk("rst_u0_phase", ifc0.out_current_state, 0);
    chk("rst_u0_busy", ifc0.out_busy, 0);
    chk("rst_u0_count", ifc0.out_iteration_count, 0);
    chk("rst_u0_sel", ifc0.out_select_stochastic, 0);
    chk("rst_u0_solved", ifc0.out_solved, 0);
    chk("rst_u0_timeout", ifc0.out_timeout, 0);
    chk("rst_u0_wderr", ifc0.out_watchdog_error, 0);
    chk("rst_u1_phase", ifc1.out_current_state, 0);
    chk("rst_u2_busy", ifc2.out_busy, 0);
    rst = 1'b0;
    tick();

    // ---- u0: run until a stochastic move, then reset asynchronously
    ifc0.in_start = 1'b1;
    tick();
    ifc0.in_start = 1'b0;
    chk("u0_setup_phase", ifc0.out_current_state, 0);
    chk("u0_setup_busy", ifc0.out_busy, 1);
    ifc0.in_setup_done = 1'b1;
    tick();
    ifc0.in_setup_done = 1'b0;
    chk("u0_first_check", ifc0.out_current_state, 3);
    m_lfsr  = 16'hACE1;
    m_count = 0;
    got     = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      u0_move(s);
      if (s) got = 1'b1;
      else   u0_finish(1'b0);
    end
    chk("u0_reached_stochastic", got, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_u0_phase", ifc0.out_current_state, 0);
    chk("arst_u0_busy", ifc0.out_busy, 0);
    chk("arst_u0_count", ifc0.out_iteration_count, 0);
    chk("arst_u0_sel", ifc0.out_select_stochastic, 0);
    tick();
    rst = 1'b0;
    tick();

    // ---- u0: 20 iterations against the reference LFSR from the seed
    m_lfsr  = 16'hACE1;
    m_count = 0;
    ifc0.in_start = 1'b1;
    tick();
    ifc0.in_start = 1'b0;
    tick(2);
    chk("u0_setup_wait", ifc0.out_current_state, 0);
    ifc0.in_setup_done = 1'b1;
    tick();
    ifc0.in_setup_done = 1'b0;
    chk("u0_check_after_setup", ifc0.out_current_state, 3);
    chk("u0_count_zero", ifc0.out_iteration_count, 0);
    for (int i = 0; i < 20; i++) begin
      u0_move(s);
      if (i == 0) begin
        // 0xACE1 -> 0x59C3, low byte 0xC3 >= 128: probabilistic.
        chk("u0_first_choice_hand", ifc0.out_select_stochastic, 0);
        ifc0.in_stochastic_ready = 1'b1;
        ifc0.in_check_done       = 1'b1;
        tick();
        ifc0.in_stochastic_ready = 1'b0;
        ifc0.in_check_done       = 1'b0;
        chk("u0_foreign_done_ignored", ifc0.out_current_state, 2);
      end
      u0_finish(s);
      if (i == 4) begin
        ifc0.in_start = 1'b1;
        tick();
        ifc0.in_start = 1'b0;
        chk("u0_start_busy_phase", ifc0.out_current_state, 3);
        chk("u0_start_busy_count", ifc0.out_iteration_count, m_count);
      end
      if (i == 5) begin
        ifc0.in_all_satisfied = 1'b1;
        tick();
        ifc0.in_all_satisfied = 1'b0;
        chk("u0_sat_unqualified", ifc0.out_current_state, 3);
        chk("u0_sat_unqualified_solved", ifc0.out_solved, 0);
      end
    end

    // ---- u0: abort during CHECK
    ifc0.in_abort = 1'b1;
    tick();
    ifc0.in_abort = 1'b0;
    chk("u0_abort_phase", ifc0.out_current_state, 0);
    chk("u0_abort_busy", ifc0.out_busy, 0);
    chk("u0_abort_count", ifc0.out_iteration_count, 0);
    chk("u0_abort_sel", ifc0.out_select_stochastic, 0);
    m_count = 0;

    // ---- u0: two moves then solve, restart from SOLVED, immediate solve
    ifc0.in_start = 1'b1;
    tick();
    ifc0.in_start = 1'b0;
    ifc0.in_setup_done = 1'b1;
    tick();
    ifc0.in_setup_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      u0_move(s);
      u0_finish(s);
    end
    ifc0.in_check_done    = 1'b1;
    ifc0.in_all_satisfied = 1'b1;
    tick();
    ifc0.in_check_done    = 1'b0;
    ifc0.in_all_satisfied = 1'b0;
    chk("u0_solved_phase", ifc0.out_current_state, 0);
    chk("u0_solved_flag", ifc0.out_solved, 1);
    chk("u0_solved_busy", ifc0.out_busy, 0);
    chk("u0_solved_count", ifc0.out_iteration_count, 2);
    ifc0.in_start = 1'b1;
    tick();
    ifc0.in_start = 1'b0;
    chk("u0_restart_solved", ifc0.out_solved, 0);
    chk("u0_restart_count", ifc0.out_iteration_count, 0);
    chk("u0_restart_sel", ifc0.out_select_stochastic, 0);
    chk("u0_restart_busy", ifc0.out_busy, 1);
    tick(1);
    ifc0.in_setup_done = 1'b1;
    tick();
    ifc0.in_setup_done = 1'b0;
    chk("u0_imm_check", ifc0.out_current_state, 3);
    ifc0.in_check_done    = 1'b1;
    ifc0.in_all_satisfied = 1'b1;
    tick();
    ifc0.in_check_done    = 1'b0;
    ifc0.in_all_satisfied = 1'b0;
    chk("u0_imm_phase", ifc0.out_current_state, 0);
    chk("u0_imm_solved", ifc0.out_solved, 1);
    chk("u0_imm_count", ifc0.out_iteration_count, 0);
    tick(2);
    chk("u0_solved_sticky", ifc0.out_solved, 1);

    // ---- u1: always stochastic, iteration budget of 3
    ifc1.in_start = 1'b1;
    tick();
    ifc1.in_start = 1'b0;
    chk("u1_setup_phase", ifc1.out_current_state, 0);
    ifc1.in_setup_done = 1'b1;
    tick();
    ifc1.in_setup_done = 1'b0;
    chk("u1_check0", ifc1.out_current_state, 3);
    for (int i = 1; i <= 3; i++) begin
      ifc1.in_check_done = 1'b1;
      tick();
      ifc1.in_check_done = 1'b0;
      chk("u1_select_phase", ifc1.out_current_state, 0);
      tick();
      chk("u1_move_phase", ifc1.out_current_state, 1);
      chk("u1_move_sel", ifc1.out_select_stochastic, 1);
      chk("u1_move_count", ifc1.out_iteration_count, i);
      ifc1.in_stochastic_ready = 1'b1;
      tick();
      ifc1.in_stochastic_ready = 1'b0;
      chk("u1_check_phase", ifc1.out_current_state, 3);
    end
    ifc1.in_check_done = 1'b1;
    tick();
    ifc1.in_check_done = 1'b0;
    chk("u1_to_phase", ifc1.out_current_state, 0);
    chk("u1_to_flag", ifc1.out_timeout, 1);
    chk("u1_to_wderr", ifc1.out_watchdog_error, 0);
    chk("u1_to_count", ifc1.out_iteration_count, 3);
    chk("u1_to_busy", ifc1.out_busy, 0);
    tick(3);
    chk("u1_to_sticky", ifc1.out_timeout, 1);
    ifc1.in_start = 1'b1;
    tick();
    ifc1.in_start = 1'b0;
    chk("u1_restart_timeout", ifc1.out_timeout, 0);
    chk("u1_restart_count", ifc1.out_iteration_count, 0);
    chk("u1_restart_busy", ifc1.out_busy, 1);

    // ---- u2: always probabilistic; watchdog stall and done-in-last-cycle
    ifc2.in_start = 1'b1;
    tick();
    ifc2.in_start = 1'b0;
    ifc2.in_setup_done = 1'b1;
    tick();
    ifc2.in_setup_done = 1'b0;
    chk("u2_check0", ifc2.out_current_state, 3);
    ifc2.in_check_done = 1'b1;
    tick();
    ifc2.in_check_done = 1'b0;
    tick();
    chk("u2_move_phase", ifc2.out_current_state, 2);
    chk("u2_move_sel", ifc2.out_select_stochastic, 0);
    chk("u2_move_count", ifc2.out_iteration_count, 1);
    tick(15);
    chk("u2_stall_still_prob", ifc2.out_current_state, 2);
    tick();
    chk("u2_wd_phase", ifc2.out_current_state, 0);
    chk("u2_wd_timeout", ifc2.out_timeout, 1);
    chk("u2_wd_error", ifc2.out_watchdog_error, 1);
    ifc2.in_start = 1'b1;
    tick();
    ifc2.in_start = 1'b0;
    chk("u2_restart_wderr", ifc2.out_watchdog_error, 0);
    chk("u2_restart_timeout", ifc2.out_timeout, 0);
    ifc2.in_setup_done = 1'b1;
    tick();
    ifc2.in_setup_done = 1'b0;
    ifc2.in_check_done = 1'b1;
    tick();
    ifc2.in_check_done = 1'b0;
    tick();
    chk("u2_move2_phase", ifc2.out_current_state, 2);
    chk("u2_move2_count", ifc2.out_iteration_count, 1);
    tick(15);
    ifc2.in_probabilistic_done = 1'b1;
    tick();
    ifc2.in_probabilistic_done = 1'b0;
    chk("u2_done_wins_phase", ifc2.out_current_state, 3);
    chk("u2_done_wins_wderr", ifc2.out_watchdog_error, 0);
    chk("u2_done_wins_timeout", ifc2.out_timeout, 0);
    ifc2.in_check_done = 1'b1;
    tick();
    ifc2.in_check_done = 1'b0;
    tick();
    chk("u2_move3_phase", ifc2.out_current_state, 2);
    chk("u2_move3_count", ifc2.out_iteration_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/solver_phase_sequencer.md
Name: solver_phase_sequencer

Overview:
- Top-level phase scheduler for the MCMC constraint solver.
- Generates the 2-bit global phase code (0 setup, 1 stochastic, 2 probabilistic, 3 checking) consumed by the stochastic and probabilistic control units.
- Each iteration uses a 16-bit LFSR to choose between a stochastic move and a probabilistic move. It counts iterations and declares solved, timeout, or watchdog error.
- Sits between the host start/abort interface and the per-phase control units.

Parameters:
- ITER_WIDTH, 16, width of the iteration counter.
- MAX_ITERATIONS, 1000, number of move iterations allowed before timeout (1..2^ITER_WIDTH-1).
- STOCHASTIC_THRESHOLD, 128, 9-bit move-selection threshold, range 0..256. Stochastic is chosen when {1'b0,lfsr[7:0]} < threshold.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- PHASE_TIMEOUT, 4096, maximum cycles allowed in any waiting phase.
- WD_WIDTH, 13, width of the watchdog counter; must satisfy 2^WD_WIDTH >= PHASE_TIMEOUT.

Ports:
- in_clk  input  1  clock; all state updates on posedge.
- in_reset  input  1  asynchronous, active-high reset.
- in_start  input  1  single-cycle pulse; starts or restarts a solve.
- in_abort  input  1  forces a return to IDLE.
- in_setup_done  input  1  setup datapath finished.
- in_stochastic_ready  input  1  ready output of the stochastic control unit.
- in_probabilistic_done  input  1  probabilistic unit finished.
- in_check_done  input  1  clause checker result valid.
- in_all_satisfied  input  1  all enabled clauses satisfied; qualified by in_check_done.
- out_current_state  output  2  global phase code.
- out_select_stochastic  output  1  move choice latched in the last SELECT.
- out_iteration_count  output  ITER_WIDTH  number of moves issued.
- out_busy  output  1  high in SETUP, SELECT, STOCHASTIC, PROBABILISTIC and CHECK.
- out_solved  output  1  sticky; high in SOLVED.
- out_timeout  output  1  sticky; high in TIMEOUT.
- out_watchdog_error  output  1  sticky; high in TIMEOUT when entry was caused by the watchdog.

Behaviour:
- Reset values: state IDLE; lfsr=LFSR_SEED; all outputs 0; watchdog counter 0.
- Phase code mapping: IDLE, SETUP, SELECT, SOLVED and TIMEOUT drive 0; STOCHASTIC drives 1; PROBABILISTIC drives 2; CHECK drives 3.
  - SELECT deliberately drives 0 for one cycle, re-arming the downstream units for the next iteration.
- Outputs are registered, or decoded from registered state only.
- State transitions:
  - IDLE: in_start -> SETUP.
  - SETUP: in_setup_done -> CHECK. The initial assignment is always checked first.
  - CHECK, with in_check_done=1:
    - in_all_satisfied=1 -> SOLVED.
    - else if out_iteration_count==MAX_ITERATIONS -> TIMEOUT (out_watchdog_error=0).
    - else -> SELECT.
  - SELECT (exactly 1 cycle):
    - lfsr advances once (Fibonacci, taps 16,14,13,11; shift left, feedback into bit 0).
    - out_select_stochastic <= ({1'b0,lfsr_next[7:0]} < STOCHASTIC_THRESHOLD).
    - out_iteration_count increments.
    - Next state is STOCHASTIC if the choice is 1, else PROBABILISTIC.
  - STOCHASTIC: in_stochastic_ready -> CHECK.
  - PROBABILISTIC: in_probabilistic_done -> CHECK.
  - SOLVED / TIMEOUT: hold until in_start -> SETUP. Entering SETUP clears out_iteration_count, the sticky flags and out_select_stochastic. The LFSR is not reseeded.
- LFSR advances only in SELECT. Threshold 0 always selects probabilistic; threshold 256 always selects stochastic.
- Watchdog:
  - Counter clears on every state change and counts while in SETUP, STOCHASTIC, PROBABILISTIC or CHECK.
  - If it reaches PHASE_TIMEOUT-1 and that state's done input is low in the same cycle -> TIMEOUT with out_watchdog_error=1.
  - If done is high in the expiry cycle, done wins.
- Priority, highest first: in_reset (async) > in_abort > normal transitions.
  - in_abort in any state goes to IDLE next cycle and clears all outputs except the LFSR.
- in_start is ignored while out_busy=1.
- Done inputs that arrive in a state that does not wait on them are ignored. in_all_satisfied is ignored without in_check_done.
- out_iteration_count never wraps, because TIMEOUT is reached at MAX_ITERATIONS.
- Latency:
  - in_start at cycle 0 -> SETUP at cycle 1.
  - A done pulse -> next state on the following edge.
  - A failing check -> move phase 2 cycles later, via SELECT.

Test Plan:
- Reset mid-operation: assert in_reset asynchronously in STOCHASTIC -> all outputs 0 immediately, out_current_state=0; after release, lfsr=16'hACE1.
- Immediate solve: start, setup_done at cycle 3, check_done+all_satisfied -> phase sequence 0,3,0; out_solved=1; out_iteration_count=0.
- THRESHOLD=256, MAX_ITERATIONS=3, checks always fail -> phases 0,3,0,1,3,0,1,3,0,1,3 then TIMEOUT; out_timeout=1, out_watchdog_error=0, count=3.
- THRESHOLD=0 -> every move uses phase 2. Default threshold, seed ACE1 -> choices match a reference LFSR model for 20 iterations.
- PHASE_TIMEOUT=16, stall in PROBABILISTIC -> TIMEOUT after 16 cycles with out_watchdog_error=1. Done asserted in cycle 15 -> CHECK, no error.
- in_abort during CHECK -> IDLE next cycle, flags clear. in_start while busy is ignored. in_start in SOLVED restarts with count=0.
